// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller:
// opcodes, FSM states, ALUOp / ALUSrcB / PCSource codes and the control bundle.
package ctrl_pkg;

  localparam int OPC_W = 6;
  localparam int ST_W  = 4;

  localparam logic [OPC_W-1:0] OP_R    = 6'h00;
  localparam logic [OPC_W-1:0] OP_J    = 6'h02;
  localparam logic [OPC_W-1:0] OP_BEQ  = 6'h04;
  localparam logic [OPC_W-1:0] OP_BNE  = 6'h05;
  localparam logic [OPC_W-1:0] OP_ADDI = 6'h08;
  localparam logic [OPC_W-1:0] OP_SLTI = 6'h0A;
  localparam logic [OPC_W-1:0] OP_LW   = 6'h23;
  localparam logic [OPC_W-1:0] OP_SW   = 6'h2B;

  typedef enum logic [ST_W-1:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_R_EXEC   = 4'd7,
    S_R_WB     = 4'd8,
    S_I_EXEC   = 4'd9,
    S_I_WB     = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_RTYPE = 3'b010,
    ALU_SLT   = 3'b011
  } alu_op_e;

  localparam logic [1:0] SRCB_RT     = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
    logic       retire;
  } ctrl_t;

  function automatic logic op_legal(input logic [OPC_W-1:0] op);
    return op == OP_R    || op == OP_J    ||
           op == OP_BEQ  || op == OP_BNE  ||
           op == OP_ADDI || op == OP_SLTI ||
           op == OP_LW   || op == OP_SW;
  endfunction

endpackage

// File: rtl/mc_out_decode.sv
// Combinational state + opcode -> control-vector decode.
// Ports: state_i, opcode_i, mem_ready_i in; ctrl_o (full control bundle) out.
module mc_out_decode
  import ctrl_pkg::*;
(
  input  state_e           state_i,
  input  logic [OPC_W-1:0] opcode_i,
  input  logic             mem_ready_i,
  output ctrl_t            ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
        // PC+4 and IR only commit once the fetch word is actually there
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMM_SH;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.illegal   = !op_legal(opcode_i);
      end
      S_MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.retire     = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.iord      = 1'b1;
        ctrl_o.retire    = mem_ready_i;
      end
      S_R_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_RT;
        ctrl_o.alu_op    = ALU_RTYPE;
      end
      S_R_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.retire    = 1'b1;
      end
      S_I_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = (opcode_i == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      S_I_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.retire    = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_RT;
        ctrl_o.alu_op        = ALU_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
        ctrl_o.branch_ne     = (opcode_i == OP_BNE);
        ctrl_o.retire        = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_JUMP;
        ctrl_o.retire    = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-subset control FSM: sequences fetch/decode/exec/mem/wb.
// Ports: clk_i, rst_i (async active-low), opcode_i, mem_ready_i in; datapath controls, state_o, illegal_o, retire_o out.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int OPC_W = 6,
  parameter int ST_W  = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [OPC_W-1:0] opcode_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             pc_write_cond_o,
  output logic             branch_ne_o,
  output logic             iord_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             ir_write_o,
  output logic             mem_to_reg_o,
  output logic             reg_dst_o,
  output logic             reg_write_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [2:0]       alu_op_o,
  output logic [1:0]       pc_source_o,
  output logic [ST_W-1:0]  state_o,
  output logic             illegal_o,
  output logic             retire_o
);

  state_e state_q, state_d;
  ctrl_t  ctrl;
  logic [5:0] op;

  assign op = 6'(opcode_i);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:     state_d = S_MEM_ADDR;
          OP_R:             state_d = S_R_EXEC;
          OP_ADDI, OP_SLTI: state_d = S_I_EXEC;
          OP_BEQ, OP_BNE:   state_d = S_BRANCH;
          OP_J:             state_d = S_JUMP;
          default:          state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR: state_d = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_d = mem_ready_i ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   state_d = mem_ready_i ? S_FETCH : S_MEM_WR;
      S_R_EXEC:   state_d = S_R_WB;
      S_I_EXEC:   state_d = S_I_WB;
      default:    state_d = S_FETCH;
    endcase
  end

  // Outputs decode straight from state_q, so an async reset clears
  // any in-flight strobe without waiting for a clock edge.
  mc_out_decode u_dec (
    .state_i     (state_q),
    .opcode_i    (op),
    .mem_ready_i (mem_ready_i),
    .ctrl_o      (ctrl)
  );

  assign pc_write_o      = ctrl.pc_write;
  assign pc_write_cond_o = ctrl.pc_write_cond;
  assign branch_ne_o     = ctrl.branch_ne;
  assign iord_o          = ctrl.iord;
  assign mem_read_o      = ctrl.mem_read;
  assign mem_write_o     = ctrl.mem_write;
  assign ir_write_o      = ctrl.ir_write;
  assign mem_to_reg_o    = ctrl.mem_to_reg;
  assign reg_dst_o       = ctrl.reg_dst;
  assign reg_write_o     = ctrl.reg_write;
  assign alu_src_a_o     = ctrl.alu_src_a;
  assign alu_src_b_o     = ctrl.alu_src_b;
  assign alu_op_o        = ctrl.alu_op;
  assign pc_source_o     = ctrl.pc_source;
  assign illegal_o       = ctrl.illegal;
  assign retire_o        = ctrl.retire;
  assign state_o         = ST_W'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed-vector bench for multicycle_ctrl.
// Ports: none; drives the DUT and prints one summary line.
module tb_multicycle_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [5:0] opcode_i = '0;
  logic       mem_ready_i = 1'b0;
  logic       pc_write_o, pc_write_cond_o, branch_ne_o, iord_o;
  logic       mem_read_o, mem_write_o, ir_write_o, mem_to_reg_o;
  logic       reg_dst_o, reg_write_o, alu_src_a_o;
  logic [1:0] alu_src_b_o, pc_source_o;
  logic [2:0] alu_op_o;
  logic [3:0] state_o;
  logic       illegal_o, retire_o;

  int vectors = 0;
  int miscompares = 0;

  multicycle_ctrl #(.OPC_W(6), .ST_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i),
    .mem_ready_i(mem_ready_i), .pc_write_o(pc_write_o),
    .pc_write_cond_o(pc_write_cond_o), .branch_ne_o(branch_ne_o),
    .iord_o(iord_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .ir_write_o(ir_write_o),
    .mem_to_reg_o(mem_to_reg_o), .reg_dst_o(reg_dst_o),
    .reg_write_o(reg_write_o), .alu_src_a_o(alu_src_a_o),
    .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
    .pc_source_o(pc_source_o), .state_o(state_o),
    .illegal_o(illegal_o), .retire_o(retire_o)
  );

  always #5 clk_i = ~clk_i;

  logic [19:0] obs;
  assign obs = {pc_write_o, pc_write_cond_o, branch_ne_o, iord_o,
                mem_read_o, mem_write_o, ir_write_o, mem_to_reg_o,
                reg_dst_o, reg_write_o, alu_src_a_o, alu_src_b_o,
                alu_op_o, pc_source_o, illegal_o, retire_o};

  localparam logic [19:0] PCW  = 20'h80000;
  localparam logic [19:0] PWC  = 20'h40000;
  localparam logic [19:0] BNEB = 20'h20000;
  localparam logic [19:0] IORD = 20'h10000;
  localparam logic [19:0] MRD  = 20'h08000;
  localparam logic [19:0] MWR  = 20'h04000;
  localparam logic [19:0] IRW  = 20'h02000;
  localparam logic [19:0] M2R  = 20'h01000;
  localparam logic [19:0] RDST = 20'h00800;
  localparam logic [19:0] RW   = 20'h00400;
  localparam logic [19:0] SRCA = 20'h00200;
  localparam logic [19:0] SB1  = 20'h00080;
  localparam logic [19:0] SB2  = 20'h00100;
  localparam logic [19:0] SB3  = 20'h00180;
  localparam logic [19:0] AOS  = 20'h00010;
  localparam logic [19:0] AOR  = 20'h00020;
  localparam logic [19:0] AOL  = 20'h00030;
  localparam logic [19:0] PS1  = 20'h00004;
  localparam logic [19:0] PS2  = 20'h00008;
  localparam logic [19:0] ILL  = 20'h00002;
  localparam logic [19:0] RET  = 20'h00001;

  localparam logic [19:0] F  = PCW | MRD | IRW | SB1;
  localparam logic [19:0] FW = MRD | SB1;
  localparam logic [19:0] D  = SB3;

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      vectors++;
      if (state_o !== 4'd0) begin
        miscompares++;
        $display("FAIL reset_state cyc %0d: got %0d want 0", i, state_o);
      end
      vectors++;
      if (obs !== 20'h0) begin
        miscompares++;
        $display("FAIL reset_outs cyc %0d: got %h want 0", i, obs);
      end
    end
    rst_i = 1'b1;
    mem_ready_i = 1'b1;
    #1;
    vectors++;
    if (state_o !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_release_idle: got %0d want 0", state_o);
    end
    @(negedge clk_i);
    vectors++;
    if (state_o !== 4'd1) begin
      miscompares++;
      $display("FAIL reset_to_fetch: got %0d want 1", state_o);
    end
  endtask

  task automatic test_r_i_type();
    logic [5:0]  op [3] = '{6'h00, 6'h08, 6'h0A};
    logic [19:0] ex3 [3] = '{SRCA | AOR, SRCA | SB2, SRCA | SB2 | AOL};
    logic [19:0] ex4 [3] = '{RW | RDST | RET, RW | RET, RW | RET};
    int          st3 [3] = '{7, 9, 9};
    int          st4 [3] = '{8, 10, 10};
    for (int k = 0; k < 3; k++) begin
      int          st [4];
      logic [19:0] ex [4];
      int          rets = 0;
      st = '{1, 2, st3[k], st4[k]};
      ex = '{F, D, ex3[k], ex4[k]};
      opcode_i = op[k];
      for (int i = 0; i < 4; i++) begin
        mem_ready_i = 1'b1;
        #1;
        rets += int'(retire_o);
        vectors++;
        if (state_o !== 4'(st[i])) begin
          miscompares++;
          $display("FAIL rit op%h step %0d state: got %0d want %0d", op[k], i, state_o, st[i]);
        end
        vectors++;
        if (obs !== ex[i]) begin
          miscompares++;
          $display("FAIL rit op%h step %0d outs: got %h want %h", op[k], i, obs, ex[i]);
        end
        @(negedge clk_i);
      end
      vectors++;
      if (rets !== 1) begin
        miscompares++;
        $display("FAIL rit op%h retire_count: got %0d want 1", op[k], rets);
      end
    end
  endtask

  task automatic test_load_store();
    int          st [12] = '{1, 2, 3, 4, 4, 4, 5, 1, 1, 2, 3, 6};
    logic        rd [12] = '{1, 1, 1, 0, 0, 1, 1, 0, 1, 1, 1, 1};
    logic [19:0] ex [12] = '{F, D, SRCA | SB2, IORD | MRD, IORD | MRD,
                             IORD | MRD, RW | M2R | RET, FW, F, D,
                             SRCA | SB2, MWR | IORD | RET};
    for (int i = 0; i < 12; i++) begin
      opcode_i = (i < 7) ? 6'h23 : 6'h2B;
      mem_ready_i = rd[i];
      #1;
      vectors++;
      if (state_o !== 4'(st[i])) begin
        miscompares++;
        $display("FAIL ldst step %0d state: got %0d want %0d", i, state_o, st[i]);
      end
      vectors++;
      if (obs !== ex[i]) begin
        miscompares++;
        $display("FAIL ldst step %0d outs: got %h want %h", i, obs, ex[i]);
      end
      @(negedge clk_i);
    end
  endtask

  task automatic test_branch_jump();
    logic [5:0]  op [9] = '{6'h05, 6'h05, 6'h05, 6'h04, 6'h04, 6'h04,
                            6'h02, 6'h02, 6'h02};
    int          st [9] = '{1, 2, 11, 1, 2, 11, 1, 2, 12};
    logic [19:0] ex [9] = '{F, D, SRCA | AOS | PWC | PS1 | BNEB | RET,
                            F, D, SRCA | AOS | PWC | PS1 | RET,
                            F, D, PCW | PS2 | RET};
    for (int i = 0; i < 9; i++) begin
      opcode_i = op[i];
      mem_ready_i = 1'b1;
      #1;
      vectors++;
      if (state_o !== 4'(st[i])) begin
        miscompares++;
        $display("FAIL brj step %0d state: got %0d want %0d", i, state_o, st[i]);
      end
      vectors++;
      if (obs !== ex[i]) begin
        miscompares++;
        $display("FAIL brj step %0d outs: got %h want %h", i, obs, ex[i]);
      end
      @(negedge clk_i);
    end
  endtask

  task automatic test_illegal();
    int          st [3] = '{1, 2, 1};
    logic [19:0] ex [3] = '{F, D | ILL, F};
    int          ills = 0;
    opcode_i = 6'h3F;
    for (int i = 0; i < 3; i++) begin
      mem_ready_i = 1'b1;
      #1;
      ills += int'(illegal_o);
      vectors++;
      if (state_o !== 4'(st[i])) begin
        miscompares++;
        $display("FAIL illegal step %0d state: got %0d want %0d", i, state_o, st[i]);
      end
      vectors++;
      if (obs !== ex[i]) begin
        miscompares++;
        $display("FAIL illegal step %0d outs: got %h want %h", i, obs, ex[i]);
      end
      if (i < 2) @(negedge clk_i);
    end
    vectors++;
    if (ills !== 1) begin
      miscompares++;
      $display("FAIL illegal_pulses: got %0d want 1", ills);
    end
  endtask

  task automatic test_reset_mid_write();
    int          st [4] = '{1, 2, 3, 6};
    logic        rd [4] = '{1, 1, 1, 0};
    logic [19:0] ex [4] = '{F, D, SRCA | SB2, MWR | IORD};
    opcode_i = 6'h2B;
    for (int i = 0; i < 4; i++) begin
      mem_ready_i = rd[i];
      #1;
      vectors++;
      if (state_o !== 4'(st[i])) begin
        miscompares++;
        $display("FAIL rstwr step %0d state: got %0d want %0d", i, state_o, st[i]);
      end
      vectors++;
      if (obs !== ex[i]) begin
        miscompares++;
        $display("FAIL rstwr step %0d outs: got %h want %h", i, obs, ex[i]);
      end
      if (i < 3) @(negedge clk_i);
    end
    rst_i = 1'b0;
    #1;
    vectors++;
    if (mem_write_o !== 1'b0 || state_o !== 4'd0) begin
      miscompares++;
      $display("FAIL rstwr_abort: got mw=%b st=%0d want mw=0 st=0", mem_write_o, state_o);
    end
    @(negedge clk_i);
    vectors++;
    if (obs !== 20'h0) begin
      miscompares++;
      $display("FAIL rstwr_hold outs: got %h want 0", obs);
    end
    rst_i = 1'b1;
    mem_ready_i = 1'b1;
    @(negedge clk_i);
    vectors++;
    if (state_o !== 4'd1) begin
      miscompares++;
      $display("FAIL rstwr_restart: got %0d want 1", state_o);
    end
  endtask

  initial begin
    test_reset();
    test_r_i_type();
    test_load_store();
    test_branch_jump();
    test_illegal();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control FSM that sequences a multi-cycle version of the MIPS-subset datapath: one shared ALU, one unified instruction/data memory, PC, IR, register file.
- Breaks each instruction into FETCH / DECODE / EXEC / MEM / WB steps and drives every datapath mux select and write enable.
- Stalls on a memory-ready handshake.
- Sits beside the datapath top level, taking the place of the single-cycle Decoder. The ALU_Ctrl block still consumes alu_op_o together with the funct field.

Parameters:
- OPC_W, 6, opcode width
- ST_W, 4, state register width

Ports:
- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  reset; asynchronous, active-low
- opcode_i  in  6  IR[31:26], valid from DECODE onward
- mem_ready_i  in  1  memory access completes this cycle
- pc_write_o  out  1  unconditional PC load
- pc_write_cond_o  out  1  PC load if branch condition is true
- branch_ne_o  out  1  branch condition: 0 = zero_o, 1 = !zero_o
- iord_o  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read_o  out  1  memory read strobe
- mem_write_o  out  1  memory write strobe
- ir_write_o  out  1  IR load enable
- mem_to_reg_o  out  1  write-back source: 0 = ALUOut, 1 = MDR
- reg_dst_o  out  1  destination register: 0 = rt, 1 = rd
- reg_write_o  out  1  register file write enable
- alu_src_a_o  out  1  ALU A input: 0 = PC, 1 = rs
- alu_src_b_o  out  2  ALU B input: 0 = rt, 1 = const 4, 2 = sign-extended imm, 3 = sign-extended imm << 2
- alu_op_o  out  3  ALU operation class, to ALU_Ctrl
- pc_source_o  out  2  PC source: 0 = ALU result, 1 = ALUOut, 2 = jump target
- state_o  out  ST_W  current state, for debug and verification
- illegal_o  out  1  one-cycle pulse on an unsupported opcode
- retire_o  out  1  one-cycle pulse in the final cycle of each instruction

Behaviour:
- Reset (rst_i = 0, asynchronous):
  - state forced to IDLE(0).
  - All outputs 0. alu_op_o = 0, state_o = 0.
- After reset release:
  - IDLE → FETCH unconditionally on the next edge.
  - IDLE is never re-entered without a reset.
- Opcodes:
  - R = 0x00, ADDI = 0x08, SLTI = 0x0A, BEQ = 0x04, BNE = 0x05, LW = 0x23, SW = 0x2B, J = 0x02.
- alu_op_o encoding:
  - 000 add, 001 sub, 010 R-type (use funct), 011 slt.
- States and transitions. Outputs not listed are 0.
  - FETCH(1): mem_read, iord = 0, src_a = 0, src_b = 1, alu_op = 000, pc_source = 0.
    - ir_write and pc_write are asserted only when mem_ready_i = 1.
    - Holds in FETCH while mem_ready_i = 0; advances to DECODE when it is 1.
  - DECODE(2): src_a = 0, src_b = 3, alu_op = 000 (branch target into ALUOut). Next state by opcode:
    - LW / SW → MEM_ADDR
    - R → R_EXEC
    - ADDI / SLTI → I_EXEC
    - BEQ / BNE → BRANCH
    - J → JUMP
    - any other opcode → FETCH, with illegal_o = 1 and retire_o = 0
  - MEM_ADDR(3): src_a = 1, src_b = 2, alu_op = 000. Goes to MEM_RD for LW, MEM_WR for SW.
  - MEM_RD(4): mem_read, iord = 1.
    - Holds while mem_ready_i = 0, then goes to MEM_WB.
  - MEM_WB(5): reg_write, mem_to_reg = 1, reg_dst = 0, retire. Goes to FETCH.
  - MEM_WR(6): mem_write, iord = 1.
    - Holds while mem_ready_i = 0.
    - Retires in the cycle where mem_ready_i = 1, then goes to FETCH.
  - R_EXEC(7): src_a = 1, src_b = 0, alu_op = 010. Goes to R_WB.
  - R_WB(8): reg_write, reg_dst = 1, mem_to_reg = 0, retire. Goes to FETCH.
  - I_EXEC(9): src_a = 1, src_b = 2, alu_op = 000 for ADDI, 011 for SLTI. Goes to I_WB.
  - I_WB(10): reg_write, reg_dst = 0, mem_to_reg = 0, retire. Goes to FETCH.
  - BRANCH(11): src_a = 1, src_b = 0, alu_op = 001, pc_write_cond, pc_source = 1, branch_ne = (opcode == BNE), retire. Goes to FETCH.
  - JUMP(12): pc_write, pc_source = 2, retire. Goes to FETCH.
  - Unused encodings 13–15 → FETCH; all outputs 0.
- Latency in cycles, with zero memory wait:
  - R / ADDI / SLTI / SW: 4
  - LW: 5
  - BEQ / BNE / J: 3
  - Each wait cycle adds one in FETCH, MEM_RD or MEM_WR.
- mem_read_o / mem_write_o remain asserted, with constant iord_o, for every wait cycle.
- Reset during a stall aborts immediately: no write strobe survives the reset assertion.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode constants
  - state encodings
  - ALUOp encodings
  - ALUSrcB and PCSource encodings
- Separate state register from next-state/output logic inside one module.
- One optional sub-module, mc_out_decode: a combinational state+opcode → control-vector decode.

Test Plan:
- Reset held low for 3 cycles, then released → state_o = 0, all outputs 0 during reset; state_o = 1 one cycle after release.
- R-type (opcode 0x00), mem_ready_i = 1 → states 1, 2, 7, 8; alu_op 010 in R_EXEC; reg_write = 1 and reg_dst = 1 in R_WB; exactly 1 retire in 4 cycles.
- LW (0x23), mem_ready_i low for 2 cycles in MEM_RD → states 1, 2, 3, 4, 4, 4, 5; iord = 1 and mem_read = 1 for all 3 MEM_RD cycles; mem_to_reg = 1 in MEM_WB.
- BNE (0x05) → states 1, 2, 11; in BRANCH: pc_write_cond = 1, branch_ne = 1, pc_source = 1, alu_op = 001.
- Illegal opcode 0x3F → DECODE goes to FETCH; illegal_o pulses once; no reg_write, mem_write or retire.
- Reset asserted mid-MEM_WR with mem_ready_i = 0 → mem_write_o drops in the same cycle; restart from IDLE, then FETCH.
